// File: rtl/seq_detect_p.sv
// seq_detect_p: runtime-loadable serial pattern detector with a Mealy match
// pulse, an overlap/non-overlap mode and an optional saturating match counter.
// Optional feature macro: SEQ_DETECT_P_CNT_EN (builds the match counter;
// when undefined match_cnt is tied to 0).
module seq_detect_p #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             go_valid,
  input  logic             go,
  output logic             op,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  // History keeps one bit fewer than the pattern; the live go bit completes it.
  localparam int HIST_W = (PAT_W > 1) ? PAT_W - 1 : 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovl_q, ovl_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]  fill_q, fill_d;
  logic              armed_q, armed_d;

  logic [LEN_W-1:0]  eff_len;
  logic [LEN_W-1:0]  fill_inc;
  logic [HIST_W:0]   win;
  logic [PAT_W-1:0]  len_msk;
  logic              match;

  // Low-len bits set; everything at or above len is ignored.
  function automatic logic [PAT_W-1:0] mask_of(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) m[i] = (i < int'(len));
    return m;
  endfunction

  // Clamp the requested length, build the window and evaluate the match.
  always_comb begin
    eff_len  = (int'(pat_len) > PAT_W) ? LEN_W'(PAT_W) : pat_len;
    fill_inc = (int'(fill_q) < PAT_W - 1) ? fill_q + LEN_W'(1) : fill_q;
    win      = {hist_q, go};
    len_msk  = mask_of(len_q);
    match    = go_valid && !load && (state_q == RUN) &&
               ((win[PAT_W-1:0] & len_msk) == (pat_q & len_msk));
  end

  assign op    = match;
  assign armed = armed_q;

  // Next-state: load wins over the serial stream; idle-valid cycles hold.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    armed_d = armed_q;
    if (load) begin
      pat_d   = pattern & mask_of(eff_len);
      len_d   = eff_len;
      ovl_d   = overlap;
      hist_d  = '0;
      fill_d  = '0;
      armed_d = (eff_len != '0);
      if (eff_len == '0)      state_d = IDLE;
      else if (eff_len == 1)  state_d = RUN;
      else                    state_d = FILL;
    end else if (go_valid) begin
      hist_d = HIST_W'({hist_q, go});
      fill_d = fill_inc;
      case (state_q)
        FILL: if (int'(fill_inc) >= int'(len_q) - 1) state_d = RUN;
        RUN: begin
          // Non-overlapping mode restarts the history after every hit.
          if (match && !ovl_q) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = (len_q == 1) ? RUN : FILL;
          end
        end
        default: ;
      endcase
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

`ifdef SEQ_DETECT_P_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match count, cleared by load.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                        cnt_d = '0;
    else if (match && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_p.sv
// Bench for seq_detect_p: a bit-level reference model pushes the expected op
// for every driven cycle into a queue, popped and compared in the same cycle.
module tb_seq_detect_p;
  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic clk = 1'b0, reset_n = 1'b0, load = 1'b0, overlap = 1'b0;
  logic go_valid = 1'b0, go = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] pat_len = '0;
  logic op, armed;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0, errors = 0;

  seq_detect_p #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .go_valid(go_valid), .go(go),
    .op(op), .armed(armed), .match_cnt(match_cnt));

  always #5 clk = ~clk;

  // Reference model state
  int          mlen = 0, mn = 0, mcnt = 0;
  logic [31:0] mpat = '0, mh = '0;
  bit          movl = 0;
  logic        expq[$];

  function automatic logic model_bit(input logic gv, input logic g);
    logic [31:0] bits, mk;
    logic        m;
    m = 1'b0;
    if (gv) begin
      bits = {mh[30:0], g};
      mk   = (mlen == 0) ? 32'd0 : ((32'd1 << mlen) - 32'd1);
      if (mn < 31) mn++;
      m = (mlen != 0) && (mn >= mlen) && ((bits & mk) == (mpat & mk));
      if (m && mcnt < (1 << CNT_W) - 1) mcnt++;
      if (m && !movl) begin mh = '0; mn = 0; end
      else mh = bits;
    end
    return m;
  endfunction

  function automatic int exp_cnt();
`ifdef SEQ_DETECT_P_CNT_EN
    return mcnt;
`else
    return 0;
`endif
  endfunction

  task automatic drive_bit(input logic gv, input logic g);
    @(negedge clk);
    load = 1'b0; go_valid = gv; go = g;
    expq.push_back(model_bit(gv, g));
    #1;
  endtask

  task automatic do_load(input logic [PAT_W-1:0] p, input int len, input bit ovl,
                         input logic gv, input logic g);
    @(negedge clk);
    load = 1'b1; pattern = p; pat_len = LEN_W'(len); overlap = ovl;
    go_valid = gv; go = g;
    mlen = (len > PAT_W) ? PAT_W : len;
    mpat = 32'(p); movl = ovl; mh = '0; mn = 0; mcnt = 0;
    expq.push_back(1'b0);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    load = 1'b0; go_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic e;
    @(negedge clk);
    reset_n = 1'b0; load = 1'b0; go_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mlen = 0; mpat = '0; mh = '0; mn = 0; mcnt = 0; movl = 0;
    #1;
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed got=%b want=0", armed); end
    checks++; if (match_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
    drive_bit(1'b1, 1'b1);
    e = expq.pop_front();
    checks++; if (op !== e) begin errors++; $display("FAIL reset_op got=%b want=%b", op, e); end
  endtask

  task automatic test_overlap();
    logic [6:0] s = 7'b1011011;
    logic e; int np = 0;
    do_load(8'b1011, 4, 1, 1'b0, 1'b0);
    e = expq.pop_front();
    checks++; if (op !== e) begin errors++; $display("FAIL ovl_load_op got=%b want=%b", op, e); end
    for (int i = 6; i >= 0; i--) begin
      drive_bit(1'b1, s[i]);
      e = expq.pop_front(); np += int'(op === 1'b1);
      checks++; if (op !== e) begin errors++; $display("FAIL ovl_op bit%0d got=%b want=%b", 7 - i, op, e); end
    end
    checks++; if (np != 2) begin errors++; $display("FAIL ovl_pulses got=%0d want=2", np); end
    idle_cycle();
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL ovl_armed got=%b want=1", armed); end
    checks++; if (int'(match_cnt) != exp_cnt()) begin errors++; $display("FAIL ovl_cnt got=%0d want=%0d", match_cnt, exp_cnt()); end
  endtask

  task automatic test_no_overlap();
    logic [10:0] s = 11'b10110111011;
    logic e; int np = 0;
    do_load(8'b1011, 4, 0, 1'b0, 1'b0);
    e = expq.pop_front();
    checks++; if (op !== e) begin errors++; $display("FAIL novl_load_op got=%b want=%b", op, e); end
    for (int i = 10; i >= 0; i--) begin
      drive_bit(1'b1, s[i]);
      e = expq.pop_front(); np += int'(op === 1'b1);
      checks++; if (op !== e) begin errors++; $display("FAIL novl_op bit%0d got=%b want=%b", 11 - i, op, e); end
    end
    checks++; if (np != 2) begin errors++; $display("FAIL novl_pulses got=%0d want=2", np); end
    idle_cycle();
    checks++; if (int'(match_cnt) != exp_cnt()) begin errors++; $display("FAIL novl_cnt got=%0d want=%0d", match_cnt, exp_cnt()); end
  endtask

  task automatic test_gaps();
    logic e;
    do_load(8'b101, 3, 1, 1'b0, 1'b0);
    void'(expq.pop_front());
    drive_bit(1'b1, 1'b1); e = expq.pop_front();
    checks++; if (op !== e) begin errors++; $display("FAIL gap_b1 got=%b want=%b", op, e); end
    drive_bit(1'b1, 1'b0); e = expq.pop_front();
    checks++; if (op !== e) begin errors++; $display("FAIL gap_b2 got=%b want=%b", op, e); end
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b0, 1'(i % 2 == 0));
      e = expq.pop_front();
      checks++; if (op !== 1'b0 || op !== e) begin errors++; $display("FAIL gap_idle%0d got=%b want=0", i, op); end
    end
    drive_bit(1'b1, 1'b1); e = expq.pop_front();
    checks++; if (op !== 1'b1 || op !== e) begin errors++; $display("FAIL gap_final got=%b want=1", op); end
  endtask

  task automatic test_back_to_back();
    logic e; int np = 0;
    do_load(8'b11, 2, 1, 1'b0, 1'b0);
    void'(expq.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, 1'b1);
      e = expq.pop_front(); np += int'(op === 1'b1);
      checks++; if (op !== e) begin errors++; $display("FAIL b2b_op bit%0d got=%b want=%b", i + 1, op, e); end
    end
    checks++; if (np != 3) begin errors++; $display("FAIL b2b_pulses got=%0d want=3", np); end
  endtask

  task automatic test_saturation();
    logic e; int np = 0;
    do_load(8'b1, 1, 0, 1'b0, 1'b0);
    void'(expq.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive_bit(1'b1, 1'b1);
      e = expq.pop_front(); np += int'(op === 1'b1);
      checks++; if (op !== e) begin errors++; $display("FAIL sat_op bit%0d got=%b want=%b", i + 1, op, e); end
    end
    checks++; if (np != 20) begin errors++; $display("FAIL sat_pulses got=%0d want=20", np); end
    idle_cycle(); idle_cycle();
    checks++; if (int'(match_cnt) != exp_cnt()) begin errors++; $display("FAIL sat_cnt got=%0d want=%0d", match_cnt, exp_cnt()); end
  endtask

  task automatic test_reset_disable();
    logic e;
    do_load(8'b1011, 4, 1, 1'b0, 1'b0);
    void'(expq.pop_front());
    drive_bit(1'b1, 1'b1); void'(expq.pop_front());
    drive_bit(1'b1, 1'b0); void'(expq.pop_front());
    drive_bit(1'b1, 1'b1); void'(expq.pop_front());
    test_reset();
    do_load(8'b1011, 0, 1, 1'b0, 1'b0);
    void'(expq.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive_bit(1'b1, 1'($urandom_range(0, 1)));
      e = expq.pop_front();
      checks++; if (op !== 1'b0 || op !== e) begin errors++; $display("FAIL dis_op bit%0d got=%b want=0", i, op); end
    end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL dis_armed got=%b want=0", armed); end
  endtask

  task automatic test_clamp_collision();
    logic [7:0] s = 8'hA5;
    logic e; int np = 0;
    do_load(8'b1, 1, 1, 1'b0, 1'b0);
    void'(expq.pop_front());
    drive_bit(1'b1, 1'b1); void'(expq.pop_front());
    idle_cycle();
    checks++; if (int'(match_cnt) != exp_cnt()) begin errors++; $display("FAIL clamp_pre_cnt got=%0d want=%0d", match_cnt, exp_cnt()); end
    do_load(8'hA5, 12, 0, 1'b1, 1'b1);
    e = expq.pop_front();
    checks++; if (op !== e) begin errors++; $display("FAIL clamp_load_op got=%b want=%b", op, e); end
    idle_cycle();
    checks++; if (match_cnt !== '0) begin errors++; $display("FAIL clamp_cnt_clr got=%0d want=0", match_cnt); end
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL clamp_armed got=%b want=1", armed); end
    for (int i = 7; i >= 0; i--) begin
      drive_bit(1'b1, s[i]);
      e = expq.pop_front(); np += int'(op === 1'b1);
      checks++; if (op !== e) begin errors++; $display("FAIL clamp_op bit%0d got=%b want=%b", 8 - i, op, e); end
    end
    checks++; if (np != 1) begin errors++; $display("FAIL clamp_pulses got=%0d want=1", np); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_back_to_back();
    test_saturation();
    test_reset_disable();
    test_clamp_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detect_p.md
# seq_detect_p

Parametrised serial pattern detector: the generalised successor to the team's fixed 8-state `go`/`op` Mealy detector. The pattern, its length and the overlap mode are runtime-loadable rather than hard-coded in states. It sits on a single-bit serial control stream and flags each completed match with a same-cycle Mealy pulse. It also keeps a saturating match count for status readback.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits, minimum 1.
- `CNT_W`, default 8: width of the match counter.
- `LEN_W`, derived as $clog2(PAT_W+1): width of `pat_len`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `load` in 1: capture `pattern`, `pat_len` and `overlap`.
- `pattern` in PAT_W: target bits. Bit `pat_len-1` is received first and bit 0 last.
- `pat_len` in LEN_W: active length. 0 disables the detector. Values above PAT_W are clamped to PAT_W.
- `overlap` in 1: 1 means overlapping matches count, 0 means non-overlapping.
- `go_valid` in 1: qualifies `go`.
- `go` in 1: serial data bit.
- `op` out 1: Mealy match pulse.
- `armed` out 1: registered, 1 when a nonzero length is loaded.
- `match_cnt` out CNT_W: registered saturating count of matches.

## Operation
- Internal registers:
  - `pat_r`, `len_r` and `ovl_r`, captured on `load`.
  - `hist`, PAT_W-1 bits: the previous valid bits, newest in the LSB.
  - `fill`: count of valid bits held, saturating at PAT_W-1.
- State machine:
  - **IDLE**: `len_r` is 0.
  - **FILL**: fewer than `len_r`-1 bits held.
  - **RUN**: enough history held that the next bit can complete a match.
- Transitions:
  - From IDLE, `load` with an effective length ≥1 goes to FILL, or straight to RUN when the length is 1.
  - From FILL, when `fill` reaches `len_r`-1, go to RUN.
  - From RUN with `ovl_r`=0, a match clears `fill` and `hist` and returns to FILL, or stays in RUN when the length is 1.
  - From RUN with `ovl_r`=1, stay in RUN.
  - From any state, `load` with effective length 0 goes to IDLE.
- Match rule:
  - Window is {hist, go}, masked to its low `len_r` bits.
  - `match` = `go_valid` & (state==RUN) & (masked window == `pat_r` masked to `len_r` bits).
- Outputs:
  - `op` = `match`, combinational from registered state plus `go`/`go_valid`. It is asserted only in the matching cycle.
  - On each `go_valid` cycle without `load`, `go` shifts into `hist`.
  - `match_cnt` increments on a match and holds at 2^CNT_W-1.
- `load` has priority:
  - It clears `hist`, `fill` and `match_cnt`.
  - A `go` bit in the same cycle is discarded, and `op` is 0 in that cycle.
- `pattern` bits at or above `pat_len` are ignored.

## Timing
- Reset: while `reset_n`=0 at an edge, all registers go to 0. This gives state IDLE, `armed`=0, `match_cnt`=0 and `op`=0.
- Reset mid-stream discards the pattern. A new `load` is required.
- `op` has zero latency: it appears in the same cycle as the completing `go` bit.
- `match_cnt` reflects a match on the following edge.
- `armed` updates on the edge after `load`.
- Cycles with `go_valid`=0 leave all state unchanged and hold `op`=0. Gaps of any length are transparent.
- Throughput: one bit per cycle, with back-to-back matches allowed.
  - With `ovl_r`=1, matches can be as close as one bit apart for periodic patterns.
  - With `ovl_r`=0, matches are at least `len_r` bits apart.

## Configuration
- Macro: `SEQ_DETECT_P_CNT_EN`.
- Defined: `match_cnt` register and saturating increment are implemented as described.
- Undefined:
  - No counter logic is built, and `match_cnt` is tied to 0.
  - `op`, `armed` and the FSM are unaffected.
  - The port list is unchanged.

## Test plan
1. **Overlap on.** Reset, then `load` pattern=4'b1011, `pat_len`=4, `overlap`=1. Stream the valid bits 1,0,1,1,0,1,1.
   - `op` pulses on bits 4 and 7.
   - `match_cnt`=2.
2. **Overlap off.** Same load with `overlap`=0. Stream 1,0,1,1,0,1,1,1,0,1,1.
   - `op` pulses on bits 4 and 11 only.
   - `match_cnt`=2.
3. **Valid gaps.** Pattern 3'b101, `pat_len`=3. Send 1, 0, then 5 cycles with `go_valid`=0 and `go` toggling, then 1.
   - `op`=1 only on the final valid cycle.
   - `op`=0 during the gap.
4. **Saturation.** Build with `CNT_W`=4 and the macro defined. Load pattern bit 1, `pat_len`=1. Send 20 valid 1s.
   - `op` is high on all 20 valid cycles.
   - `match_cnt` is 15 and holds.
5. **Reset and disable.** Pattern 1011 with 3 bits already sent. Drive `reset_n`=0 for one edge.
   - `armed`=0 and `match_cnt`=0.
   - Next bit 1 gives no `op`.
   - Reload with `pat_len`=0: `armed` stays 0 and no `op` for any stream.
6. **Clamp and load collision.** Build with `PAT_W`=8. `load` pattern=8'hA5, `pat_len`=12.
   - Behaves as length 8.
   - `load` asserted together with `go_valid` discards that bit and clears `match_cnt`.
   - Stream A5 MSB-first gives exactly one `op`.
